seg_scan_ctrl: RTL and testbench

- Parametrised multiplexed seven-segment scan controller, successor to the fixed six-digit dynamic display driver.
- Converts an unsigned binary value to BCD sequentially and applies leading-zero blanking, a sign digit, decimal points, overflow indication and per-digit blink.
- Drives one digit at a time through a one-hot `sel` bus, feeding the board's segment and select shift-register/pin stage.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_scan_ctrl_if.sv | 26 ++
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared constants, glyph decoding and converter state type for the
// multiplexed seven-segment scan controller.
package seg_pkg;

  // Segment patterns are {dp,g,f,e,d,c,b,a}, active-low (common anode).
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Digit glyphs 0..9; element [n] is the pattern for digit n.
  localparam logic [9:0][7:0] SEG_DIGITS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    COMMIT
  } conv_state_e;

  // Glyph for one BCD digit; codes above 9 show as blank.
  function automatic logic [7:0] seg_decode(input logic [3:0] bcd);
    if (bcd <= 4'd9) return SEG_DIGITS[bcd];
    return SEG_BLANK;
  endfunction

  // Largest value representable in n decimal digits (10^n - 1).
  function automatic logic [63:0] pow10_minus1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Bundle of the value/attribute inputs and the scan outputs of the
// seven-segment scan controller.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 6,
  parameter int DATA_W = 20
);

  logic [DATA_W-1:0] data;
  logic [DIGITS-1:0] point;
  logic              sign;
  logic              seg_en;
  logic [DIGITS-1:0] blink;
  logic [7:0]        seg;
  logic [DIGITS-1:0] sel;

  modport master (
    output data, point, sign, seg_en, blink,
    input  seg, sel
  );

  modport slave (
    input  data, point, sign, seg_en, blink,
    output seg, sel
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one LOAD cycle, DATA_W SHIFT cycles,
// one COMMIT cycle during which bcd/overflow are valid and done is high.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  done
);

  localparam int SR_W  = 4 * DIGITS + DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10_minus1(DIGITS);

  conv_state_e      state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_adj;
  logic [CNT_W-1:0] bit_q;
  logic             ovf_q;

  // Add-3 correction on every BCD nibble that is 5 or more before shifting.
  always_comb begin
    // NOTE: assign every always_comb output a default first, so no path leaves it unassigned and a latch is inferred.
    sr_adj = sr_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (sr_q[DATA_W + 4*d +: 4] >= 4'd5)
        sr_adj[DATA_W + 4*d +: 4] = sr_q[DATA_W + 4*d +: 4] + 4'd3;
    end
  end

  // Next-state logic for the free-running LOAD/SHIFT/COMMIT loop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (start) state_d = SHIFT;
      SHIFT:   if (bit_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // State register; reset restarts at LOAD and drops any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // Shift register, bit counter and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      bit_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: if (start) begin
          sr_q  <= {{(4*DIGITS){1'b0}}, bin};
          bit_q <= '0;
          ovf_q <= 64'(bin) > OVF_LIMIT;
        end
        SHIFT: begin
          sr_q  <= sr_adj << 1;
          bit_q <= bit_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd      = sr_q[SR_W-1 -: 4*DIGITS];
  assign overflow = ovf_q;
  assign done     = (state_q == COMMIT);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: sequential binary-to-BCD,
// leading-zero blanking, sign placement, decimal points, overflow display,
// per-digit blink and registered one-hot digit scanning.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int          DIGITS       = 6,
  parameter int          DATA_W       = 20,
  parameter logic [15:0] CNT_MAX      = 16'd49_999,
  parameter logic [7:0]  BLINK_FRAMES = 8'd250
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(DIGITS);

  logic [4*DIGITS-1:0] conv_bcd;
  logic                conv_ovf;
  logic                conv_done;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .start    (1'b1),
    .bin      (bus.data),
    .bcd      (conv_bcd),
    .overflow (conv_ovf),
    .done     (conv_done)
  );

  // Attributes captured on the same cycle the converter samples data.
  logic              at_load_q;
  logic              sign_l;
  logic [DIGITS-1:0] point_l, blink_l;

  // Track the converter's LOAD cycle and latch sign/point/blink with it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      at_load_q <= 1'b1;
      sign_l    <= 1'b0;
      point_l   <= '0;
      blink_l   <= '0;
    end else begin
      at_load_q <= conv_done;
      if (at_load_q) begin
        sign_l  <= bus.sign;
        point_l <= bus.point;
        blink_l <= bus.blink;
      end
    end
  end

  // Display registers and the values about to be committed.
  logic [DIGITS-1:0][3:0] dig_q;
  logic [DIGITS-1:0]      blank_q, point_q, blink_q;
  logic                   ovf_q, minus_en_q;
  logic [IDX_W-1:0]       minus_pos_q;

  logic [DIGITS-1:0] blank_d;
  logic              ovf_d, minus_en_d;
  logic [IDX_W-1:0]  minus_pos_d;
  logic              zero_above, pt_above, need_minus;
  int                msd;

  // Blanking mask, minus position and overflow from the fresh BCD result.
  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    pt_above   = 1'b0;
    msd        = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      pt_above   = pt_above | point_l[i];
      zero_above = zero_above & (conv_bcd[4*i +: 4] == 4'd0);
      blank_d[i] = (i > 0) && zero_above && !pt_above;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (!blank_d[i]) msd = i;
    end
    need_minus  = sign_l && (conv_bcd != '0);
    ovf_d       = conv_ovf || (need_minus && (msd == DIGITS - 1));
    minus_en_d  = need_minus;
    minus_pos_d = IDX_W'(msd + 1);
  end

  // Commit a completed conversion into the display registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dig_q       <= '0;
      blank_q     <= '1;
      point_q     <= '0;
      blink_q     <= '0;
      ovf_q       <= 1'b0;
      minus_en_q  <= 1'b0;
      minus_pos_q <= '0;
    end else if (conv_done) begin
      dig_q       <= conv_bcd;
      blank_q     <= blank_d;
      point_q     <= point_l;
      blink_q     <= blink_l;
      ovf_q       <= ovf_d;
      minus_en_q  <= minus_en_d;
      minus_pos_q <= minus_pos_d;
    end
  end

  // Scan timing: tick counter, digit index, frame counter and blink phase.
  logic [15:0]      cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       frame_q;
  logic             blink_phase_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
    end else if (!bus.seg_en) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      frame_q       <= '0;
      blink_phase_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_q <= '0;
        if (frame_q == BLINK_FRAMES - 8'd1) begin
          frame_q       <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          frame_q <= frame_q + 8'd1;
        end
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  // Pattern for the currently indexed digit, in priority order.
  logic [7:0]        seg_d;
  logic [DIGITS-1:0] sel_d;

  always_comb begin
    seg_d = seg_decode(dig_q[idx_q]);
    if (blank_q[idx_q])                           seg_d = SEG_BLANK;
    if (minus_en_q && (idx_q == minus_pos_q))     seg_d = SEG_MINUS;
    if (point_q[idx_q])                           seg_d[7] = 1'b0;
    if (ovf_q)                                    seg_d = SEG_MINUS;
    if (blink_phase_q && blink_q[idx_q])          seg_d = SEG_BLANK;
    sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
  end

  // Register sel and seg together so they always change on the same edge.
  logic [7:0]        seg_q;
  logic [DIGITS-1:0] sel_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_q <= SEG_BLANK;
      sel_q <= '0;
    end else if (!bus.seg_en) begin
      seg_q <= SEG_BLANK;
      sel_q <= '0;
    end else begin
      seg_q <= seg_d;
      sel_q <= sel_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.sel = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random
// values, compared against a decimal-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 6;
  localparam int DATA_W = 20;
  localparam int HOLD   = 6;             // CNT_MAX + 1
  localparam int FRAME  = DIGITS * HOLD;

  logic clk = 1'b0;
  logic rst_n;

  seg_scan_ctrl_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  seg_scan_ctrl #(
    .DIGITS       (DIGITS),
    .DATA_W       (DATA_W),
    .CNT_MAX      (16'd5),
    .BLINK_FRAMES (8'd2)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pos    = 0;   // cycles since seg_en last rose
  int grace  = 0;   // cycles in which the previous value is still acceptable

  int unsigned cur_data, old_data;
  bit          cur_sign, old_sign;
  bit [5:0]    cur_point, old_point, cur_blink, old_blink;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input int n);
    case (n)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Expected pattern for digit d, from the decimal value and its attributes.
  function automatic logic [7:0] model_seg(input int unsigned data, input bit sign,
                                           input bit [5:0] point, input bit [5:0] blink,
                                           input int d, input bit phase);
    int unsigned v;
    int          width;
    logic [7:0]  g;
    if (phase && blink[d]) return 8'hFF;
    if (data > 999_999) return 8'hBF;
    width = 1;
    v = data;
    while (v >= 10) begin
      v = v / 10;
      width++;
    end
    for (int k = 0; k < DIGITS; k++) if (point[k] && (k + 1 > width)) width = k + 1;
    if (sign && (data != 0)) begin
      if (width >= DIGITS) return 8'hBF;
      if (d == width) return 8'hBF;
    end
    g = (d < width) ? glyph(int'((data / pow10(d)) % 10)) : 8'hFF;
    if (point[d]) g[7] = 1'b0;
    return g;
  endfunction

  task automatic apply(input int unsigned d, input bit s, input bit [5:0] p, input bit [5:0] b);
    bus.data  = DATA_W'(d);
    bus.sign  = s;
    bus.point = p;
    bus.blink = b;
    cur_data  = d;
    cur_sign  = s;
    cur_point = p;
    cur_blink = b;
  endtask

  // Check n consecutive scan cycles against the model.
  task automatic scan(input int n);
    int         dg;
    bit         phase;
    logic [7:0] exp, alt;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      dg    = (pos / HOLD) % DIGITS;
      phase = ((pos / FRAME) / 2) % 2 == 1;
      check("sel", {2'b00, bus.sel}, 8'(1 << dg));
      exp = model_seg(cur_data, cur_sign, cur_point, cur_blink, dg, phase);
      if (grace > 0) begin
        grace--;
        alt = model_seg(old_data, old_sign, old_point, old_blink, dg, phase);
        if (bus.seg === alt) exp = alt;
      end
      check("seg", bus.seg, exp);
      pos++;
    end
  endtask

  task automatic enable();
    bus.seg_en = 1'b1;
    pos = 0;
  endtask

  task automatic disable_chk();
    bus.seg_en = 1'b0;
    @(negedge clk);
    check("off_sel", {2'b00, bus.sel}, 8'h00);
    check("off_seg", bus.seg, 8'hFF);
  endtask

  // Let at least two conversion loops complete with seg_en low.
  task automatic settle_and_frame(input int unsigned d, input bit s, input bit [5:0] p);
    apply(d, s, p, 6'b0);
    repeat (50) @(negedge clk);
    enable();
    scan(FRAME);
    disable_chk();
  endtask

  initial begin
    int unsigned rd;
    bit          rs;
    bit [5:0]    rp;

    rst_n      = 1'b1;
    bus.seg_en = 1'b0;
    apply(0, 1'b0, 6'b0, 6'b0);

    // Reset held 30 ns; outputs idle throughout.
    #1  rst_n = 1'b0;
    #10 check("rst_seg", bus.seg, 8'hFF);
        check("rst_sel", {2'b00, bus.sel}, 8'h00);
    #14 check("rst_seg", bus.seg, 8'hFF);
        check("rst_sel", {2'b00, bus.sel}, 8'h00);
    #6  rst_n = 1'b1;

    // Idle until seg_en rises, while the signed value converts.
    apply(4321, 1'b1, 6'b000010, 6'b0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("idle_seg", bus.seg, 8'hFF);
      check("idle_sel", {2'b00, bus.sel}, 8'h00);
    end

    // Signed value with point: F9 24 B0 99 BF FF.
    enable();
    scan(FRAME);

    // Drop enable mid-digit 3, then re-enable.
    scan(3 * HOLD + 2);
    disable_chk();
    enable();
    scan(2 * HOLD);
    disable_chk();

    // Leading zeros and dp.
    settle_and_frame(5, 1'b0, 6'b000100);

    // Overflow cases.
    settle_and_frame(1_000_000, 1'b0, 6'b0);
    settle_and_frame(100_000, 1'b1, 6'b0);
    settle_and_frame(99_999, 1'b1, 6'b0);

    // Edge values.
    settle_and_frame(0, 1'b1, 6'b0);
    settle_and_frame(999_999, 1'b0, 6'b000001);
    settle_and_frame(0, 1'b0, 6'b001000);

    // Random values and attributes.
    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 3))
        0:       rd = $urandom_range(0, 9);
        1:       rd = $urandom_range(0, 9_999);
        2:       rd = $urandom_range(0, 999_999);
        default: rd = $urandom_range(0, (1 << DATA_W) - 1);
      endcase
      rs = 1'($urandom_range(0, 1));
      rp = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 63)) : 6'b0;
      settle_and_frame(rd, rs, rp);
    end

    // Blink on digit 0 across eight frames.
    apply(1234, 1'b0, 6'b0, 6'b000001);
    repeat (50) @(negedge clk);
    enable();
    scan(8 * FRAME + 15);

    // Data change mid-frame while scanning.
    old_data  = cur_data;
    old_sign  = cur_sign;
    old_point = cur_point;
    old_blink = cur_blink;
    apply(5678, 1'b0, 6'b0, 6'b000001);
    grace = 44;
    scan(3 * FRAME);
    disable_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
